binarize_threshold_ctrl: RTL and testbench
==========================================

// Module: binarize_threshold_ctrl
// PURPOSE
//   Per-frame threshold controller for the RGB binarizer stage. Measures mean luma of
//   each measured frame, divides sum by pixel count with a serial divider, and drives
//   the 12-bit threshold used on the following frames. A manual override bypasses it.
// PARAMETERS
//   DATA_W     12     colour channel / threshold width
//   CNT_W      20     pixel counter width (max 2^CNT_W-1 pixels per frame)
//   DEFAULT_TH 2048   threshold after reset
//   MIN_PIX    1024   frames with fewer valid pixels leave threshold unchanged
//   TH_MIN     256    lower clamp on computed threshold
//   TH_MAX     3840   upper clamp on computed threshold
// PORTS
//   iCLK        in   1       clock
//   iRST_n      in   1       asynchronous active-low reset
//   iFrameStart in   1       one-cycle pulse, first cycle of a frame
//   iFrameEnd   in   1       one-cycle pulse, cycle of the last pixel of a frame
//   iDVAL       in   1       pixel valid
//   iRed        in   DATA_W  red sample
//   iGreen      in   DATA_W  green sample
//   iBlue       in   DATA_W  blue sample
//   iManual     in   1       1 = use iManualTh
//   iManualTh   in   DATA_W  manual threshold
//   oThreshold  out  DATA_W  threshold to binarizer (registered)
//   oThValid    out  1       one-cycle pulse when oThreshold takes a computed value
//   oBusy       out  1       high in ACCUM and DIVIDE
// BEHAVIOUR
//   Reset (async, any state): state IDLE, oThreshold=DEFAULT_TH, oThValid=0, oBusy=0,
//     sum/count/divider cleared. Reset mid-DIVIDE discards the result.
//   luma = (iRed + 2*iGreen + iBlue) >> 2, 14-bit intermediate, 12-bit result.
//   States: IDLE -> ACCUM on iFrameStart. iDVAL/iFrameEnd ignored in IDLE.
//     ACCUM: each iDVAL cycle adds luma to sum (DATA_W+CNT_W bits), count+1. If
//       iFrameStart and iDVAL coincide, that pixel is the first counted. Count
//       saturates at 2^CNT_W-1; sum and count both freeze once saturated.
//     ACCUM -> DIVIDE on iFrameEnd (pixel on that cycle included).
//       iFrameStart in ACCUM restarts accumulation (sum=count=0).
//     DIVIDE: restoring divider, one quotient bit per cycle, DATA_W+CNT_W cycles.
//       If count < MIN_PIX, divider skipped: DIVIDE -> IDLE next cycle, no update.
//     UPDATE (1 cycle): new = clamp(quotient, TH_MIN, TH_MAX); -> IDLE.
//   oThreshold/oThValid update on the same edge, DATA_W+CNT_W+2 clocks after the
//     edge sampling iFrameEnd. oThValid never pulses while iManual=1.
//   iFrameStart in DIVIDE/UPDATE: that frame is not measured (no queueing).
//   iManual=1: oThreshold <= iManualTh every cycle (1-cycle latency); measurement
//     continues, results discarded. On 1->0, oThreshold holds last manual value
//     until the next computed update.
// CONFIGURATION
//   THRESH_IIR_EN defined: new = clamp(oThreshold - (oThreshold>>2) + (quotient>>2)),
//     i.e. 3/4 previous + 1/4 measured, truncated; in manual mode the filter history
//     is the manual value.
//   THRESH_IIR_EN undefined: new = clamp(quotient), no history.
// TESTING
//   Reset: oThreshold=2048, oThValid=0, oBusy=0; assert iRST_n=0 mid-DIVIDE -> same.
//   Frame of 2048 pixels R=G=B=1000 -> oThValid 34 clocks after iFrameEnd, oThreshold=1000.
//   Frame of 2048 pixels R=G=B=4095 -> oThreshold=3840 (clamp); all zero -> 256.
//   Frame with 500 valid pixels -> no oThValid, oThreshold unchanged.
//   iManual=1, iManualTh=300 -> oThreshold=300 next clock; measured frame gives no pulse.
//   iFrameStart during DIVIDE -> that frame skipped, one update only, oBusy pattern correct.
//   THRESH_IIR_EN: from 2048, frame mean 1000 -> 1786; second frame mean 1000 -> 1590.

Source files
------------

// File: rtl/binarize_threshold_ctrl_if.sv
// Pixel/frame bus between the video front end and the threshold controller.
// Latency: none (wires only); the controller registers every output it drives.
// Backpressure: none; pixels are accepted whenever iDVAL is high.
//
// Signals:
//   iFrameStart / iFrameEnd  one-cycle frame delimiters
//   iDVAL, iRed/iGreen/iBlue pixel valid and colour samples
//   iManual, iManualTh       manual threshold override
//   oThreshold, oThValid     threshold to binarizer and computed-update strobe
//   oBusy                    measurement or division in progress
// Modports: master = video source / test driver, slave = controller.
interface binarize_threshold_ctrl_if #(
   parameter int DATA_W = 12
) ();
   logic              iFrameStart;
   logic              iFrameEnd;
   logic              iDVAL;
   logic [DATA_W-1:0] iRed;
   logic [DATA_W-1:0] iGreen;
   logic [DATA_W-1:0] iBlue;
   logic              iManual;
   logic [DATA_W-1:0] iManualTh;
   logic [DATA_W-1:0] oThreshold;
   logic              oThValid;
   logic              oBusy;

   modport master (
      output iFrameStart, iFrameEnd, iDVAL, iRed, iGreen, iBlue, iManual, iManualTh,
      input  oThreshold, oThValid, oBusy
   );

   modport slave (
      input  iFrameStart, iFrameEnd, iDVAL, iRed, iGreen, iBlue, iManual, iManualTh,
      output oThreshold, oThValid, oBusy
   );
endinterface

// File: rtl/binarize_threshold_ctrl.sv
// Per-frame threshold controller: mean luma of a frame -> clamped 12-bit binarizer threshold.
// Latency: computed threshold lands DATA_W+CNT_W+2 clocks after the iFrameEnd edge; manual 1 clock.
// Backpressure: none; frames starting while dividing are simply not measured.
//
// Ports:
//   iCLK    clock
//   iRST_n  asynchronous active-low reset
//   bus     binarize_threshold_ctrl_if.slave (frame delimiters, pixels, manual override,
//           oThreshold / oThValid / oBusy)
// Build option: define THRESH_IIR_EN to smooth updates as 3/4 previous + 1/4 measured.
module binarize_threshold_ctrl #(
   parameter int DATA_W     = 12,
   parameter int CNT_W      = 20,
   parameter int DEFAULT_TH = 2048,
   parameter int MIN_PIX    = 1024,
   parameter int TH_MIN     = 256,
   parameter int TH_MAX     = 3840
) (
   input logic                    iCLK,
   input logic                    iRST_n,
   binarize_threshold_ctrl_if.slave bus
);

   localparam int SUM_W  = DATA_W + CNT_W;
   localparam int STEP_W = $clog2(SUM_W + 1);

   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
   localparam logic [CNT_W-1:0]  MIN_PIX_C = CNT_W'(MIN_PIX);
   localparam logic [SUM_W-1:0]  TH_MIN_W  = SUM_W'(TH_MIN);
   localparam logic [SUM_W-1:0]  TH_MAX_W  = SUM_W'(TH_MAX);
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SUM_W);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      DIVIDE = 2'd2,
      UPDATE = 2'd3
   } state_t;

   state_t            state;
   // sum doubles as the dividend/quotient shift register while dividing
   logic [SUM_W-1:0]  sum;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  rem;
   logic [STEP_W-1:0] divStep;

   // luma = (R + 2G + B) >> 2 with two guard bits for the intermediate sum
   logic [DATA_W+1:0] lumaSum;
   logic [DATA_W-1:0] luma;

   assign lumaSum = {2'b00, bus.iRed} + {1'b0, bus.iGreen, 1'b0} + {2'b00, bus.iBlue};
   assign luma    = DATA_W'(lumaSum >> 2);

   // One restoring-division step: shift the next dividend bit into the remainder
   logic [CNT_W:0] remShift;
   logic [CNT_W:0] divisorExt;
   logic           remGeq;

   assign remShift   = {rem, sum[SUM_W-1]};
   assign divisorExt = {1'b0, count};
   assign remGeq     = (remShift >= divisorExt);

   // Candidate threshold from the finished quotient (held in sum during UPDATE)
   logic [SUM_W-1:0]  cand;
   logic [DATA_W-1:0] newTh;

`ifdef THRESH_IIR_EN
   // History is whatever is on oThreshold, including a manual value
   assign cand = SUM_W'(bus.oThreshold) - SUM_W'(bus.oThreshold >> 2) + (sum >> 2);
`else
   assign cand = sum;
`endif

   assign newTh = (cand < TH_MIN_W) ? DATA_W'(TH_MIN) :
                  (cand > TH_MAX_W) ? DATA_W'(TH_MAX) :
                  cand[DATA_W-1:0];

   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state          <= IDLE;
         sum            <= '0;
         count          <= '0;
         rem            <= '0;
         divStep        <= '0;
         bus.oThreshold <= DATA_W'(DEFAULT_TH);
         bus.oThValid   <= 1'b0;
         bus.oBusy      <= 1'b0;
      end else begin
         bus.oThValid <= 1'b0;

         case (state)
            IDLE: begin
               if (bus.iFrameStart) begin
                  state     <= ACCUM;
                  bus.oBusy <= 1'b1;
                  // a pixel on the start cycle is the first one counted
                  sum       <= bus.iDVAL ? SUM_W'(luma) : '0;
                  count     <= bus.iDVAL ? CNT_W'(1) : '0;
               end
            end

            ACCUM: begin
               if (bus.iFrameStart) begin
                  sum   <= bus.iDVAL ? SUM_W'(luma) : '0;
                  count <= bus.iDVAL ? CNT_W'(1) : '0;
               end else if (bus.iDVAL && (count != CNT_MAX)) begin
                  // once count saturates, sum freezes too so the mean stays bounded
                  sum   <= sum + SUM_W'(luma);
                  count <= count + CNT_W'(1);
               end
               if (bus.iFrameEnd) begin
                  state   <= DIVIDE;
                  divStep <= '0;
               end
            end

            DIVIDE: begin
               if (divStep == '0) begin
                  // first DIVIDE cycle: reject short frames, otherwise arm the divider
                  if (count < MIN_PIX_C) begin
                     state     <= IDLE;
                     bus.oBusy <= 1'b0;
                  end else begin
                     rem     <= '0;
                     divStep <= STEP_W'(1);
                  end
               end else begin
                  sum <= {sum[SUM_W-2:0], remGeq};
                  rem <= remGeq ? CNT_W'(remShift - divisorExt) : remShift[CNT_W-1:0];
                  if (divStep == LAST_STEP) begin
                     state     <= UPDATE;
                     bus.oBusy <= 1'b0;
                  end else begin
                     divStep <= divStep + STEP_W'(1);
                  end
               end
            end

            UPDATE: begin
               state <= IDLE;
               if (!bus.iManual) begin
                  bus.oThreshold <= newTh;
                  bus.oThValid   <= 1'b1;
               end
            end

            default: begin
               state     <= IDLE;
               bus.oBusy <= 1'b0;
            end
         endcase

         // manual override wins over any computed result on the same edge
         if (bus.iManual) begin
            bus.oThreshold <= bus.iManualTh;
         end
      end
   end

endmodule

// File: tb/tb_binarize_threshold_ctrl.sv
// Bench for binarize_threshold_ctrl: table of frames plus hand-written corner sequences.
// Expected thresholds come from the table means and a small clamp/IIR model; a queue
// holds each frame's expected result until its observation window closes.
module tb_binarize_threshold_ctrl;

   localparam int DW = 12;

   logic iCLK   = 1'b0;
   logic iRST_n = 1'b0;

   always #5 iCLK = ~iCLK;

   binarize_threshold_ctrl_if #(.DATA_W(DW)) bus ();

   binarize_threshold_ctrl dut (
      .iCLK   (iCLK),
      .iRST_n (iRST_n),
      .bus    (bus)
   );

   typedef struct {
      int r0, g0, b0;
      int r1, g1, b1;
      int n;
      bit manual;
      int mth;
      bit expPulse;
      int expMean;
   } vec_t;

   typedef struct {
      bit pulse;
      int th;
   } exp_t;

   vec_t vecs[8];
   exp_t sbq[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int pulseCnt     = 0;
   int lastPulseCyc = 0;
   int lastPulseTh  = 0;
   int modelTh      = 2048;
   int endCyc       = 0;

   // Sample outputs 1 time unit after every rising edge
   initial begin
      forever begin
         @(posedge iCLK);
         #1;
         cyc++;
         if (bus.oThValid) begin
            pulseCnt++;
            lastPulseCyc = cyc;
            lastPulseTh  = int'(bus.oThreshold);
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, bench did not complete");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   function automatic int nextTh(input int prev, input int q);
      int v;
`ifdef THRESH_IIR_EN
      v = prev - (prev >> 2) + (q >> 2);
`else
      v = q;
`endif
      if (v < 256)  v = 256;
      if (v > 3840) v = 3840;
      return v;
   endfunction

   // Drive one frame of n valid pixels, alternating colour sets, with periodic DVAL gaps.
   // Returns with endCyc = monitor index of the edge that sampled iFrameEnd.
   task automatic driveFrame(input int r0, input int g0, input int b0,
                             input int r1, input int g1, input int b1, input int n);
      int p = 0;
      int c = 0;
      while (p < n) begin
         @(negedge iCLK);
         if (c == 10) chk("busy_accum", int'(bus.oBusy), 1);
         bus.iFrameStart = (c == 0);
         bus.iFrameEnd   = 1'b0;
         if ((c % 7) == 3) begin
            bus.iDVAL  = 1'b0;
            bus.iRed   = DW'($urandom);
            bus.iGreen = DW'($urandom);
            bus.iBlue  = DW'($urandom);
         end else begin
            bus.iDVAL  = 1'b1;
            bus.iRed   = DW'((p % 2 == 0) ? r0 : r1);
            bus.iGreen = DW'((p % 2 == 0) ? g0 : g1);
            bus.iBlue  = DW'((p % 2 == 0) ? b0 : b1);
            bus.iFrameEnd = (p == n - 1);
            p++;
         end
         c++;
      end
      @(posedge iCLK);
      #2;
      endCyc = cyc;
      @(negedge iCLK);
      bus.iFrameStart = 1'b0;
      bus.iFrameEnd   = 1'b0;
      bus.iDVAL       = 1'b0;
   endtask

   // Pop the expected result for the last frame and compare against what was observed
   task automatic checkResult(input string tag, input int p0, input int fEnd);
      exp_t e;
      e = sbq.pop_front();
      chk({tag, "_pulses"}, pulseCnt - p0, e.pulse ? 1 : 0);
      if (e.pulse) begin
         chk({tag, "_latency"}, lastPulseCyc - fEnd, 34);
         chk({tag, "_pulse_th"}, lastPulseTh, e.th);
      end
      chk({tag, "_final_th"}, int'(bus.oThreshold), e.th);
      chk({tag, "_busy_idle"}, int'(bus.oBusy), 0);
      modelTh = e.th;
   endtask

   task automatic runVec(input int idx, input vec_t v);
      exp_t e;
      int p0;
      string tag;
      tag = $sformatf("vec%0d", idx);
      @(negedge iCLK);
      bus.iManual   = v.manual;
      bus.iManualTh = DW'(v.mth);
      @(posedge iCLK);
      #1;
      if (v.manual) modelTh = v.mth;
      chk({tag, "_th_pre"}, int'(bus.oThreshold), modelTh);
      e.pulse = v.expPulse;
      e.th    = v.expPulse ? nextTh(modelTh, v.expMean) : modelTh;
      sbq.push_back(e);
      p0 = pulseCnt;
      driveFrame(v.r0, v.g0, v.b0, v.r1, v.g1, v.b1, v.n);
      chk({tag, "_busy_div"}, int'(bus.oBusy), 1);
      repeat (40) @(posedge iCLK);
      #2;
      checkResult(tag, p0, endCyc);
   endtask

   initial begin
      exp_t e;
      int   p0;
      int   endB;

      vecs[0] = '{1000, 1000, 1000, 1000, 1000, 1000, 2048, 1'b0,   0, 1'b1, 1000};
      vecs[1] = '{4095, 4095, 4095, 4095, 4095, 4095, 2048, 1'b0,   0, 1'b1, 4095};
      vecs[2] = '{   0,    0,    0,    0,    0,    0, 2048, 1'b0,   0, 1'b1,    0};
      vecs[3] = '{1000, 1000, 1000, 1000, 1000, 1000,  500, 1'b0,   0, 1'b0,    0};
      vecs[4] = '{ 100, 2000, 3000, 4000,   10,   20, 1024, 1'b0,   0, 1'b1, 1392};
      vecs[5] = '{1000, 1000, 1000, 1000, 1000, 1000, 1023, 1'b0,   0, 1'b0,    0};
      vecs[6] = '{1000, 1000, 1000, 1000, 1000, 1000, 2048, 1'b1, 300, 1'b0,    0};
      vecs[7] = '{2000, 1000, 3000, 2000, 1000, 3000, 1500, 1'b0,   0, 1'b1, 1750};

      bus.iFrameStart = 1'b0;
      bus.iFrameEnd   = 1'b0;
      bus.iDVAL       = 1'b0;
      bus.iRed        = '0;
      bus.iGreen      = '0;
      bus.iBlue       = '0;
      bus.iManual     = 1'b0;
      bus.iManualTh   = '0;

      // Reset state
      repeat (3) @(posedge iCLK);
      #1;
      chk("reset_th", int'(bus.oThreshold), 2048);
      chk("reset_valid", int'(bus.oThValid), 0);
      chk("reset_busy", int'(bus.oBusy), 0);
      @(negedge iCLK);
      iRST_n  = 1'b1;
      modelTh = 2048;

      for (int i = 0; i < 8; i++) begin
         runVec(i, vecs[i]);
      end

      // iFrameStart during DIVIDE: second frame ignored, exactly one update
      e.pulse = 1'b1;
      e.th    = nextTh(modelTh, 800);
      sbq.push_back(e);
      p0 = pulseCnt;
      driveFrame(800, 800, 800, 800, 800, 800, 2048);
      endB = endCyc;
      chk("skip_busy_div", int'(bus.oBusy), 1);
      repeat (4) @(posedge iCLK);
      driveFrame(3000, 3000, 3000, 3000, 3000, 3000, 1100);
      chk("skip_busy_after", int'(bus.oBusy), 0);
      repeat (40) @(posedge iCLK);
      #2;
      checkResult("skip", p0, endB);

      // Reset mid-DIVIDE discards the result
      driveFrame(1000, 1000, 1000, 1000, 1000, 1000, 2048);
      repeat (10) @(posedge iCLK);
      @(negedge iCLK);
      iRST_n = 1'b0;
      #1;
      chk("rst_div_th", int'(bus.oThreshold), 2048);
      chk("rst_div_valid", int'(bus.oThValid), 0);
      chk("rst_div_busy", int'(bus.oBusy), 0);
      @(negedge iCLK);
      iRST_n = 1'b1;
      p0 = pulseCnt;
      repeat (40) @(posedge iCLK);
      #2;
      chk("rst_div_pulses", pulseCnt - p0, 0);
      chk("rst_div_final_th", int'(bus.oThreshold), 2048);
      modelTh = 2048;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
